// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared ISA constants, instruction field helpers and the IF/ID controller state
// encoding for the fetch redirect controller.
package fetch_redirect_ctrl_pkg;

  localparam int INSN_W = 32;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  // Encoding is visible on the state port: RUN=0, HOLD=1, SQUASH=2.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SQUASH = 2'd2
  } fr_state_e;

  function automatic logic [5:0] insn_op(input logic [INSN_W-1:0] insn);
    return insn[31:26];
  endfunction

  function automatic logic [4:0] insn_rs(input logic [INSN_W-1:0] insn);
    return insn[25:21];
  endfunction

  function automatic logic [4:0] insn_rt(input logic [INSN_W-1:0] insn);
    return insn[20:16];
  endfunction

  function automatic logic [15:0] insn_imm16(input logic [INSN_W-1:0] insn);
    return insn[15:0];
  endfunction

  function automatic logic [25:0] insn_target(input logic [INSN_W-1:0] insn);
    return insn[25:0];
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Control interface between the PC unit (master) and the IF/ID redirect
// controller (slave). The PC unit publishes the fetch PC; the controller answers
// with branch/jump/stall requests that the PC unit samples at the next edge.
interface fetch_redirect_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] PC;
  logic              PcSel;
  logic [ADDR_W-1:0] Adress;
  logic              Jump;
  logic [25:0]       Jumpaddr;
  logic              pause;

  modport master (
    output PC,
    input  PcSel,
    input  Adress,
    input  Jump,
    input  Jumpaddr,
    input  pause
  );

  modport slave (
    input  PC,
    output PcSel,
    output Adress,
    output Jump,
    output Jumpaddr,
    output pause
  );
endinterface

// File: rtl/fetch_redirect_ctrl_redirect_decode.sv
// Combinational ID-stage decode: load-use hazard detection, branch resolution,
// jump detection and the pre-compensated branch offset for the PC unit.
module fetch_redirect_ctrl_redirect_decode
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_id_instr,
  input  logic              i_id_valid,
  input  logic [ADDR_W-1:0] i_rs_data,
  input  logic [ADDR_W-1:0] i_rt_data,
  input  logic              i_ex_memread,
  input  logic [4:0]        i_ex_rt,
  output logic              o_hazard,
  output logic              o_taken,
  output logic              o_jump,
  output logic [ADDR_W-1:0] o_adress,
  output logic [25:0]       o_jumpaddr
);

  logic [5:0]        w_op;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [15:0]       w_imm;
  logic [ADDR_W-1:0] w_imm_sext;
  logic              w_is_beq;
  logic              w_is_bne;
  logic              w_is_jmp;
  logic              w_regs_eq;

  assign w_op       = insn_op(i_id_instr);
  assign w_rs       = insn_rs(i_id_instr);
  assign w_rt       = insn_rt(i_id_instr);
  assign w_imm      = insn_imm16(i_id_instr);
  assign w_imm_sext = {{(ADDR_W-16){w_imm[15]}}, w_imm};
  assign w_regs_eq  = (i_rs_data == i_rt_data);

  // Classify the opcode held in ID.
  always_comb begin
    w_is_beq = 1'b0;
    w_is_bne = 1'b0;
    w_is_jmp = 1'b0;
    case (w_op)
      OP_BEQ:  w_is_beq = 1'b1;
      OP_BNE:  w_is_bne = 1'b1;
      OP_J:    w_is_jmp = 1'b1;
      OP_JAL:  w_is_jmp = 1'b1;
      default: w_is_jmp = 1'b0;
    endcase
  end

  // Resolve hazard/redirect; a hazard suppresses redirects so the branch
  // re-resolves with forwarded data after the stall.
  always_comb begin
    o_hazard   = 1'b0;
    o_taken    = 1'b0;
    o_jump     = 1'b0;
    o_adress   = {ADDR_W{1'b0}};
    o_jumpaddr = 26'd0;
    if (i_id_valid) begin
      o_hazard   = i_ex_memread && (i_ex_rt != 5'd0) &&
                   ((i_ex_rt == w_rs) || (i_ex_rt == w_rt));
      o_taken    = !o_hazard && ((w_is_beq && w_regs_eq) || (w_is_bne && !w_regs_eq));
      o_jump     = !o_hazard && w_is_jmp;
      // PC unit adds 4 to the fetch PC (already id_pc+4), so back off one word.
      o_adress   = w_imm_sext - {{(ADDR_W-1){1'b0}}, 1'b1};
      o_jumpaddr = insn_target(i_id_instr);
    end else begin
      o_hazard   = 1'b0;
      o_taken    = 1'b0;
      o_jump     = 1'b0;
      o_adress   = {ADDR_W{1'b0}};
      o_jumpaddr = 26'd0;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// IF/ID stage controller: owns the IF/ID register, the RUN/HOLD/SQUASH FSM and
// the saturating stall/redirect counters; decode logic lives in the submodule.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                CNT_W    = 16,
  parameter logic [ADDR_W-1:0] NOP_INSN = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 PcReSet,
  fetch_redirect_ctrl_if.slave pcu,
  input  logic [ADDR_W-1:0]    Instr,
  input  logic [ADDR_W-1:0]    rs_data,
  input  logic [ADDR_W-1:0]    rt_data,
  input  logic                 ex_memread,
  input  logic [4:0]           ex_rt,
  output logic [ADDR_W-1:0]    id_instr,
  output logic [ADDR_W-1:0]    id_pc,
  output logic                 id_valid,
  output logic                 id_bubble,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_id_instr;
  logic [ADDR_W-1:0] r_id_pc;
  logic              r_id_valid;
  fr_state_e         r_state;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_hazard;
  logic              w_taken;
  logic              w_jump;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_adress;
  logic [25:0]       w_jumpaddr;

  fetch_redirect_ctrl_redirect_decode #(
    .ADDR_W (ADDR_W)
  ) u_decode (
    .i_id_instr   (r_id_instr),
    .i_id_valid   (r_id_valid),
    .i_rs_data    (rs_data),
    .i_rt_data    (rt_data),
    .i_ex_memread (ex_memread),
    .i_ex_rt      (ex_rt),
    .o_hazard     (w_hazard),
    .o_taken      (w_taken),
    .o_jump       (w_jump),
    .o_adress     (w_adress),
    .o_jumpaddr   (w_jumpaddr)
  );

  assign w_redirect = w_taken || w_jump;

  // Decode results go back to the PC unit in the same cycle they are resolved.
  assign pcu.PcSel    = w_taken;
  assign pcu.Adress   = w_adress;
  assign pcu.Jump     = w_jump;
  assign pcu.Jumpaddr = w_jumpaddr;
  assign pcu.pause    = w_hazard;

  assign id_instr  = r_id_instr;
  assign id_pc     = r_id_pc;
  assign id_valid  = r_id_valid;
  assign id_bubble = w_hazard || !r_id_valid;
  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // IF/ID register: hold on load-use, squash wrong-path fetch on redirect.
  always_ff @(posedge clk or posedge PcReSet) begin
    if (PcReSet) begin
      r_id_instr <= NOP_INSN;
      r_id_pc    <= {ADDR_W{1'b0}};
      r_id_valid <= 1'b0;
    end else if (w_hazard) begin
      r_id_instr <= r_id_instr;
      r_id_pc    <= r_id_pc;
      r_id_valid <= r_id_valid;
    end else if (w_redirect) begin
      r_id_instr <= NOP_INSN;
      r_id_pc    <= r_id_pc;
      r_id_valid <= 1'b0;
    end else begin
      r_id_instr <= Instr;
      r_id_pc    <= pcu.PC;
      r_id_valid <= 1'b1;
    end
  end

  // Controller FSM; SQUASH ends after one cycle since ID is invalid there.
  always_ff @(posedge clk or posedge PcReSet) begin
    if (PcReSet) begin
      r_state <= ST_RUN;
    end else if (w_hazard) begin
      r_state <= ST_HOLD;
    end else if (w_redirect) begin
      r_state <= ST_SQUASH;
    end else begin
      r_state <= ST_RUN;
    end
  end

  // Saturating event counters: HOLD cycles and redirect edges.
  always_ff @(posedge clk or posedge PcReSet) begin
    if (PcReSet) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if ((r_state == ST_HOLD) && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (w_redirect && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: per-cycle vector table plus hand
// sequences for multi-cycle HOLD, counter saturation and reset mid-HOLD.
module tb_fetch_redirect_ctrl;

  localparam int CNT_W = 2;

  localparam logic [31:0] ADD  = 32'h0043_0820;  // add r1,r2,r3
  localparam logic [31:0] ADD5 = 32'h00A4_3820;  // add r7,r5,r4
  localparam logic [31:0] ADD0 = 32'h0003_0820;  // add r1,r0,r3
  localparam logic [31:0] BEQ  = 32'h10A6_0003;  // beq r5,r6,+3
  localparam logic [31:0] BNE  = 32'h14A6_0003;  // bne r5,r6,+3
  localparam logic [31:0] BEQN = 32'h10A6_FFFE;  // beq r5,r6,-2
  localparam logic [31:0] JMP  = 32'h0800_0010;  // j 0x10
  localparam logic [31:0] JAL  = 32'h0C00_0020;  // jal 0x20

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             PcReSet;
  logic [31:0]      Instr, rs_data, rt_data;
  logic             ex_memread;
  logic [4:0]       ex_rt;
  logic [31:0]      id_instr, id_pc;
  logic             id_valid, id_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  fetch_redirect_ctrl_if #(.ADDR_W(32)) pcu();

  fetch_redirect_ctrl #(
    .ADDR_W   (32),
    .CNT_W    (CNT_W),
    .NOP_INSN (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .PcReSet    (PcReSet),
    .pcu        (pcu.slave),
    .Instr      (Instr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_valid   (id_valid),
    .id_bubble  (id_bubble),
    .state      (state),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        mr;
    logic [4:0]  ert;
    logic        pcsel;
    logic [31:0] adr;
    logic        jmp;
    logic [25:0] ja;
    logic        pause;
    logic        bub;
    logic [31:0] idpc;
    logic        vld;
    logic [1:0]  st;
    logic [1:0]  stall;
    logic [1:0]  flush;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic v(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] rs,
                   input logic [31:0] rt, input logic mr, input logic [4:0] ert,
                   input logic pcsel, input logic [31:0] adr, input logic jmp,
                   input logic [25:0] ja, input logic pause, input logic bub,
                   input logic [31:0] idpc, input logic vld, input logic [1:0] st,
                   input logic [1:0] stall, input logic [1:0] flush);
    vec_t r;
    r.pc = pc; r.instr = instr; r.rs = rs; r.rt = rt; r.mr = mr; r.ert = ert;
    r.pcsel = pcsel; r.adr = adr; r.jmp = jmp; r.ja = ja; r.pause = pause; r.bub = bub;
    r.idpc = idpc; r.vld = vld; r.st = st; r.stall = stall; r.flush = flush;
    vecs.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //  pc        instr rs        rt        mr    ert    | pcsel adr           jmp  ja            pause bub   idpc      vld   st    stall flush
    v(32'h00, ADD,  32'h0,  32'h0,  1'b0, 5'd0, 1'b0, 32'h0,        1'b0, 26'h0,       1'b0, 1'b1, 32'h00, 1'b0, 2'd0, 2'd0, 2'd0);
    v(32'h04, ADD,  32'h0,  32'h0,  1'b0, 5'd0, 1'b0, 32'h81F,      1'b0, 26'h0430820, 1'b0, 1'b0, 32'h00, 1'b1, 2'd0, 2'd0, 2'd0);
    v(32'h08, ADD,  32'h0,  32'h0,  1'b0, 5'd0, 1'b0, 32'h81F,      1'b0, 26'h0430820, 1'b0, 1'b0, 32'h04, 1'b1, 2'd0, 2'd0, 2'd0);
    v(32'h0C, ADD,  32'h0,  32'h0,  1'b0, 5'd0, 1'b0, 32'h81F,      1'b0, 26'h0430820, 1'b0, 1'b0, 32'h08, 1'b1, 2'd0, 2'd0, 2'd0);
    v(32'h10, BEQ,  32'h55, 32'h55, 1'b0, 5'd0, 1'b0, 32'h81F,      1'b0, 26'h0430820, 1'b0, 1'b0, 32'h0C, 1'b1, 2'd0, 2'd0, 2'd0);
    v(32'h14, ADD,  32'h55, 32'h55, 1'b0, 5'd0, 1'b1, 32'h2,        1'b0, 26'h0A60003, 1'b0, 1'b0, 32'h10, 1'b1, 2'd0, 2'd0, 2'd0);
    v(32'h20, ADD,  32'h55, 32'h55, 1'b0, 5'd0, 1'b0, 32'h0,        1'b0, 26'h0,       1'b0, 1'b1, 32'h10, 1'b0, 2'd2, 2'd0, 2'd1);
    v(32'h24, BNE,  32'h77, 32'h77, 1'b0, 5'd0, 1'b0, 32'h81F,      1'b0, 26'h0430820, 1'b0, 1'b0, 32'h20, 1'b1, 2'd0, 2'd0, 2'd1);
    v(32'h28, ADD,  32'h77, 32'h77, 1'b0, 5'd0, 1'b0, 32'h2,        1'b0, 26'h0A60003, 1'b0, 1'b0, 32'h24, 1'b1, 2'd0, 2'd0, 2'd1);
    v(32'h2C, BNE,  32'h1,  32'h2,  1'b0, 5'd0, 1'b0, 32'h81F,      1'b0, 26'h0430820, 1'b0, 1'b0, 32'h28, 1'b1, 2'd0, 2'd0, 2'd1);
    v(32'h30, ADD,  32'h1,  32'h2,  1'b0, 5'd0, 1'b1, 32'h2,        1'b0, 26'h0A60003, 1'b0, 1'b0, 32'h2C, 1'b1, 2'd0, 2'd0, 2'd1);
    v(32'h3C, JMP,  32'h0,  32'h0,  1'b0, 5'd0, 1'b0, 32'h0,        1'b0, 26'h0,       1'b0, 1'b1, 32'h2C, 1'b0, 2'd2, 2'd0, 2'd2);
    v(32'h40, ADD,  32'h0,  32'h0,  1'b0, 5'd0, 1'b0, 32'hF,        1'b1, 26'h10,      1'b0, 1'b0, 32'h3C, 1'b1, 2'd0, 2'd0, 2'd2);
    v(32'h40, ADD5, 32'h0,  32'h0,  1'b0, 5'd0, 1'b0, 32'h0,        1'b0, 26'h0,       1'b0, 1'b1, 32'h3C, 1'b0, 2'd2, 2'd0, 2'd3);
    v(32'h44, ADD0, 32'h0,  32'h0,  1'b1, 5'd5, 1'b0, 32'h381F,     1'b0, 26'h0A43820, 1'b1, 1'b1, 32'h40, 1'b1, 2'd0, 2'd0, 2'd3);
    v(32'h44, ADD0, 32'h0,  32'h0,  1'b0, 5'd0, 1'b0, 32'h381F,     1'b0, 26'h0A43820, 1'b0, 1'b0, 32'h40, 1'b1, 2'd1, 2'd0, 2'd3);
    v(32'h48, ADD,  32'h0,  32'h0,  1'b1, 5'd0, 1'b0, 32'h81F,      1'b0, 26'h0030820, 1'b0, 1'b0, 32'h44, 1'b1, 2'd0, 2'd1, 2'd3);
    v(32'h4C, BEQN, 32'h0,  32'h0,  1'b1, 5'd3, 1'b0, 32'h81F,      1'b0, 26'h0430820, 1'b1, 1'b1, 32'h48, 1'b1, 2'd0, 2'd1, 2'd3);
    v(32'h4C, BEQN, 32'h0,  32'h0,  1'b0, 5'd0, 1'b0, 32'h81F,      1'b0, 26'h0430820, 1'b0, 1'b0, 32'h48, 1'b1, 2'd1, 2'd1, 2'd3);
    v(32'h50, ADD,  32'h9,  32'h9,  1'b0, 5'd0, 1'b1, 32'hFFFFFFFD, 1'b0, 26'h0A6FFFE, 1'b0, 1'b0, 32'h4C, 1'b1, 2'd0, 2'd2, 2'd3);
    v(32'h48, JAL,  32'h0,  32'h0,  1'b0, 5'd0, 1'b0, 32'h0,        1'b0, 26'h0,       1'b0, 1'b1, 32'h4C, 1'b0, 2'd2, 2'd2, 2'd3);
    v(32'h4C, ADD,  32'h0,  32'h0,  1'b0, 5'd0, 1'b0, 32'h1F,       1'b1, 26'h20,      1'b0, 1'b0, 32'h48, 1'b1, 2'd0, 2'd2, 2'd3);
    v(32'h80, ADD,  32'h0,  32'h0,  1'b0, 5'd0, 1'b0, 32'h0,        1'b0, 26'h0,       1'b0, 1'b1, 32'h48, 1'b0, 2'd2, 2'd2, 2'd3);

    PcReSet    = 1'b1;
    pcu.PC     = 32'h0;
    Instr      = 32'h0;
    rs_data    = 32'h0;
    rt_data    = 32'h0;
    ex_memread = 1'b0;
    ex_rt      = 5'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    PcReSet = 1'b0;
    chk("reset id_instr", id_instr, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      pcu.PC     = vecs[i].pc;
      Instr      = vecs[i].instr;
      rs_data    = vecs[i].rs;
      rt_data    = vecs[i].rt;
      ex_memread = vecs[i].mr;
      ex_rt      = vecs[i].ert;
      #1;
      chk($sformatf("row%0d PcSel", i),     {31'd0, pcu.PcSel},   {31'd0, vecs[i].pcsel});
      chk($sformatf("row%0d Adress", i),    pcu.Adress,           vecs[i].adr);
      chk($sformatf("row%0d Jump", i),      {31'd0, pcu.Jump},    {31'd0, vecs[i].jmp});
      chk($sformatf("row%0d Jumpaddr", i),  {6'd0, pcu.Jumpaddr}, {6'd0, vecs[i].ja});
      chk($sformatf("row%0d pause", i),     {31'd0, pcu.pause},   {31'd0, vecs[i].pause});
      chk($sformatf("row%0d id_bubble", i), {31'd0, id_bubble},   {31'd0, vecs[i].bub});
      chk($sformatf("row%0d id_pc", i),     id_pc,                vecs[i].idpc);
      chk($sformatf("row%0d id_valid", i),  {31'd0, id_valid},    {31'd0, vecs[i].vld});
      chk($sformatf("row%0d state", i),     {30'd0, state},       {30'd0, vecs[i].st});
      chk($sformatf("row%0d stall_cnt", i), {30'd0, stall_cnt},   {30'd0, vecs[i].stall});
      chk($sformatf("row%0d flush_cnt", i), {30'd0, flush_cnt},   {30'd0, vecs[i].flush});
      step();
    end

    // beq behind a load whose hazard persists two cycles, then reset mid-HOLD
    pcu.PC = 32'h84; Instr = BEQ; rs_data = 32'h1; rt_data = 32'h1; ex_memread = 1'b0; ex_rt = 5'd0;
    #1;
    chk("seq id_pc", id_pc, 32'h80);
    step();
    pcu.PC = 32'h88; Instr = ADD; ex_memread = 1'b1; ex_rt = 5'd5;
    #1;
    chk("seq hz pause", {31'd0, pcu.pause}, 32'd1);
    chk("seq hz PcSel", {31'd0, pcu.PcSel}, 32'd0);
    chk("seq hz bubble", {31'd0, id_bubble}, 32'd1);
    step();
    chk("seq hold1 state", {30'd0, state}, 32'd1);
    chk("seq hold1 pause", {31'd0, pcu.pause}, 32'd1);
    chk("seq hold1 PcSel", {31'd0, pcu.PcSel}, 32'd0);
    chk("seq hold1 stall", {30'd0, stall_cnt}, 32'd2);
    step();
    chk("seq hold2 state", {30'd0, state}, 32'd1);
    chk("seq hold2 stall", {30'd0, stall_cnt}, 32'd3);
    step();
    chk("seq stall sat", {30'd0, stall_cnt}, 32'd3);
    chk("seq id_pc held", id_pc, 32'h84);
    ex_memread = 1'b0;
    #1;
    chk("seq resolve PcSel", {31'd0, pcu.PcSel}, 32'd1);
    chk("seq resolve Adress", pcu.Adress, 32'h2);
    chk("seq resolve pause", {31'd0, pcu.pause}, 32'd0);
    #2;
    PcReSet = 1'b1;
    #1;
    chk("rst valid", {31'd0, id_valid}, 32'd0);
    chk("rst state", {30'd0, state}, 32'd0);
    chk("rst stall", {30'd0, stall_cnt}, 32'd0);
    chk("rst flush", {30'd0, flush_cnt}, 32'd0);
    chk("rst PcSel", {31'd0, pcu.PcSel}, 32'd0);
    chk("rst id_pc", id_pc, 32'h0);
    chk("rst id_instr", id_instr, 32'h0);
    @(posedge clk);
    #1;
    PcReSet = 1'b0;
    pcu.PC = 32'h0; Instr = ADD; rs_data = 32'h0; rt_data = 32'h0;
    #1;
    chk("post-rst state", {30'd0, state}, 32'd0);
    chk("post-rst bubble", {31'd0, id_bubble}, 32'd1);
    step();
    chk("post-rst valid", {31'd0, id_valid}, 32'd1);
    chk("post-rst id_instr", id_instr, ADD);
    chk("post-rst flush", {30'd0, flush_cnt}, 32'd0);
    chk("post-rst stall", {30'd0, stall_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
